akhil_test: RTL and testbench
=============================

AKHIL_TEST -- requirements
Module: akhil_test

Interface
REQ-001 The module SHALL have port clk, input, 1 bit, the single rising-edge clock for all state.
REQ-002 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clk.
REQ-003 The module SHALL have port A, input, 1 bit, code bit 3 (MSB).
REQ-004 The module SHALL have port B, input, 1 bit, code bit 2.
REQ-005 The module SHALL have port C, input, 1 bit, code bit 1.
REQ-006 The module SHALL have port D, input, 1 bit, code bit 0 (LSB).
REQ-007 The module SHALL have port X, output, 1 bit, registered prime-detect flag.
REQ-008 The module SHALL have port Y, output, 1 bit, registered odd-parity flag.
REQ-009 Ports SHALL be ordered A, B, C, D, X, Y, clk, rst so that positional instantiation of the first six ports is preserved.
REQ-010 The module SHALL have no parameters; width is fixed at a 4-bit code.

Function
REQ-011 The code SHALL be the 4-bit value {A,B,C,D}, giving the range 0..15.
REQ-012 The value PRIME(code) SHALL be 1 iff code is one of 2, 3, 5, 7, 11 or 13, and 0 for all other values, including 0 and 1.
REQ-013 The value PAR(code) SHALL be the XOR of A, B, C and D, so it is 1 when an odd number of code bits are set.
REQ-014 With the filter disabled, X SHALL equal PRIME and Y SHALL equal PAR of the code sampled at the previous rising edge, a latency of exactly 1 cycle.
REQ-015 X and Y SHALL be driven directly from flops, with no combinational path from the inputs to the outputs.
REQ-016 X and Y SHALL always update together from the same sampled code; no cycle SHALL show X from one code and Y from another.
REQ-017 Inputs SHALL be treated as synchronous to clk; no synchronizer SHALL be included.

Reset
REQ-018 While rst=1 at a rising edge, X and Y SHALL become 0 and all internal state SHALL clear, regardless of the inputs.
REQ-019 At the first edge with rst=0, outputs SHALL evaluate the current code normally, subject to the latency of REQ-014 or REQ-022.
REQ-020 Reset asserted mid-operation SHALL take priority over any pending update.

Configuration
REQ-021 The macro AKHIL_TEST_STABLE_EN SHALL enable an input-stability filter when it is defined.
REQ-022 With AKHIL_TEST_STABLE_EN defined, the module SHALL keep a register of the previously sampled code and a 1-bit valid flag.
REQ-023 With AKHIL_TEST_STABLE_EN defined, X and Y SHALL update only when the code sampled at the current edge equals the code sampled at the previous edge and valid=1; otherwise they SHALL hold their value.
REQ-024 With AKHIL_TEST_STABLE_EN defined, minimum latency SHALL be 2 cycles from a code change.
REQ-025 With AKHIL_TEST_STABLE_EN defined, reset SHALL clear the previous-code register to 0 and valid to 0.
REQ-026 Without AKHIL_TEST_STABLE_EN, the behaviour SHALL be exactly REQ-014.

Structure
REQ-027 Package akhil_test_pkg SHALL hold the constant PRIME_MASK = 16'h28AC (bit n set iff n is prime), and PRIME(code) SHALL be PRIME_MASK[code].
REQ-028 Package akhil_test_pkg SHALL hold the constant CODE_W = 4.
REQ-029 The stability filter SHALL be the sub-module akhil_test_stab, instantiated only under AKHIL_TEST_STABLE_EN.
REQ-030 akhil_test_stab SHALL have inputs clk, rst and code[3:0], and output upd_en.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles with code=4'b0111 -> X=0, Y=0 throughout reset.
REQ-032 Exhaustive sweep: with filter disabled, apply codes 0..15 one per cycle -> one cycle later, X=1 only for 2, 3, 5, 7, 11, 13 and Y=1 for 1, 2, 4, 7, 8, 11, 13, 14.
REQ-033 Latency: apply code=4'b0010 at edge n -> X=1 and Y=1 after edge n+1; change to 4'b0000 -> X=0 and Y=0 after the next edge.
REQ-034 Filter: with AKHIL_TEST_STABLE_EN defined, toggle between codes 5 and 6 every cycle -> X and Y never leave their reset value of 0.
REQ-035 Filter: with AKHIL_TEST_STABLE_EN defined, hold code 13 for 3 cycles -> X=1 and Y=1 after the 2nd edge.
REQ-036 Mid-operation reset: with code=4'b1011 and X=1, assert rst for 1 cycle -> X=0 and Y=0 the next cycle, then X=1 and Y=1 resume after the required latency.

Source files
------------

// File: rtl/akhil_test_pkg.sv
// Shared constants and the prime lookup for the 4-bit prime/parity detector.
package akhil_test_pkg;

   localparam int unsigned CODE_W = 4;

   // Bit n is set iff n is prime (2, 3, 5, 7, 11, 13).
   localparam logic [15:0] PRIME_MASK = 16'h28AC;

   function automatic logic prime_of(input logic [CODE_W-1:0] code);
      return PRIME_MASK[code];
   endfunction

endpackage

// File: rtl/akhil_test_stab.sv
// Input-stability filter: enables an update only when the code matches the previous sample.
module akhil_test_stab
   import akhil_test_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] code,
   output logic              upd_en
);

   logic [CODE_W-1:0] prev_q;
   logic              valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         prev_q  <= code;
         valid_q <= 1'b1;
      end
   end

   assign upd_en = valid_q && (code == prev_q);

endmodule

// File: rtl/akhil_test.sv
// Registered prime-detect (X) and odd-parity (Y) flags for the 4-bit code {A,B,C,D}.
// Define AKHIL_TEST_STABLE_EN to add the input-stability filter (akhil_test_stab).
module akhil_test
   import akhil_test_pkg::*;
(
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic X,
   output logic Y,
   input  logic clk,
   input  logic rst
);

   logic [CODE_W-1:0] code;
   logic              upd_en;
   logic              x_q;
   logic              y_q;

   assign code = {A, B, C, D};

`ifdef AKHIL_TEST_STABLE_EN
   akhil_test_stab u_stab (
      .clk    (clk),
      .rst    (rst),
      .code   (code),
      .upd_en (upd_en)
   );
`else
   assign upd_en = 1'b1;
`endif

   // Both flags share one enable so they always reflect the same sampled code.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= 1'b0;
         y_q <= 1'b0;
      end else if (upd_en) begin
         x_q <= prime_of(code);
         y_q <= ^code;
      end
   end

   assign X = x_q;
   assign Y = y_q;

endmodule

// File: tb/tb_akhil_test.sv
// Directed self-checking bench for akhil_test; covers the filtered build when
// AKHIL_TEST_STABLE_EN is defined, otherwise the direct 1-cycle-latency build.
module tb_akhil_test;

   logic A, B, C, D;
   logic X, Y;
   logic clk;
   logic rst;

   int n_checks = 0;
   int n_fail   = 0;

   akhil_test dut (
      .A   (A),
      .B   (B),
      .C   (C),
      .D   (D),
      .X   (X),
      .Y   (Y),
      .clk (clk),
      .rst (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] c);
      {A, B, C, D} = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic xe, input logic ye);
      n_checks++;
      assert (X === xe) else begin
         n_fail++;
         $error("FAIL %s.X observed=%b expected=%b", tag, X, xe);
      end
      n_checks++;
      assert (Y === ye) else begin
         n_fail++;
         $error("FAIL %s.Y observed=%b expected=%b", tag, Y, ye);
      end
   endtask

   initial begin
      logic [3:0] c;
      logic       xe, ye;

      // Reset held for two cycles with a prime, odd-parity code present.
      rst = 1'b1;
      drive(4'b0111);
      tick();
      check("reset_c1", 1'b0, 1'b0);
      tick();
      check("reset_c2", 1'b0, 1'b0);
      rst = 1'b0;

`ifdef AKHIL_TEST_STABLE_EN
      // Toggling 5/6 never passes the filter.
      for (int i = 0; i < 6; i++) begin
         drive((i % 2 == 0) ? 4'd5 : 4'd6);
         tick();
         check("toggle", 1'b0, 1'b0);
      end

      // Hold 13: first edge only arms the filter, second edge updates.
      drive(4'd13);
      tick();
      check("hold13_e1", 1'b0, 1'b0);
      tick();
      check("hold13_e2", 1'b1, 1'b1);
      tick();
      check("hold13_e3", 1'b1, 1'b1);

      // Change to 4 (non-prime, odd parity): held once, then updated.
      drive(4'd4);
      tick();
      check("chg4_e1", 1'b1, 1'b1);
      tick();
      check("chg4_e2", 1'b0, 1'b1);

      // Mid-operation reset with code 11.
      drive(4'b1011);
      tick();
      check("mid_pre1", 1'b0, 1'b1);
      tick();
      check("mid_pre2", 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      check("mid_rst", 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check("mid_post1", 1'b0, 1'b0);
      tick();
      check("mid_post2", 1'b1, 1'b1);
`else
      // Exhaustive sweep, one code per cycle, expected flags from hand-listed sets.
      for (int i = 0; i < 16; i++) begin
         c  = 4'(i);
         xe = (i == 2) || (i == 3) || (i == 5) || (i == 7) || (i == 11) || (i == 13);
         ye = (i == 1) || (i == 2) || (i == 4) || (i == 7) || (i == 8) || (i == 11) ||
              (i == 13) || (i == 14);
         drive(c);
         tick();
         check($sformatf("sweep_%0d", i), xe, ye);
      end

      // Latency: outputs must not follow inputs before the edge.
      drive(4'b0010);
      #2;
      check("lat_pre_edge", 1'b0, 1'b0);
      tick();
      check("lat_code2", 1'b1, 1'b1);
      drive(4'b0000);
      #2;
      check("lat_hold", 1'b1, 1'b1);
      tick();
      check("lat_code0", 1'b0, 1'b0);

      // Mid-operation reset with code 11.
      drive(4'b1011);
      tick();
      check("mid_pre", 1'b1, 1'b1);
      rst = 1'b1;
      tick();
      check("mid_rst", 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check("mid_post", 1'b1, 1'b1);

      // Even-parity prime and odd-parity non-prime to separate X from Y.
      drive(4'd5);
      tick();
      check("code5", 1'b1, 1'b0);
      drive(4'd14);
      tick();
      check("code14", 1'b0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
